// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types and constants for the pipeline stall/flush controller
package pipeline_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_e;

    localparam int REG_ZERO = 0;

    // Width of a down-counter that must hold values 0..cycles; never narrower than one bit.
    function automatic int wait_cnt_width(input int cycles);
        int w;
        w = 1;
        while ((1 << w) < (cycles + 1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/pipeline_stall_flush_ctrl_hazard.sv
// rtl/pipeline_stall_flush_ctrl_hazard.sv - load-use hazard compare between ID/EX load and IF/ID sources
module hazard_detect_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      idex_mem_read,
    input  logic [REG_ADDR_WIDTH-1:0] idex_rt,
    input  logic [REG_ADDR_WIDTH-1:0] ifid_rs,
    input  logic [REG_ADDR_WIDTH-1:0] ifid_rt,
    output logic                      load_use
);

    logic dest_valid;
    logic src_match;

    // Register zero is hardwired, so a load targeting it can never feed a consumer.
    assign dest_valid = (idex_rt != REG_ADDR_WIDTH'(REG_ZERO));
    assign src_match  = (idex_rt == ifid_rs) || (idex_rt == ifid_rt);
    assign load_use   = idex_mem_read && dest_valid && src_match;

endmodule

// File: rtl/pipeline_stall_flush_ctrl.sv
// rtl/pipeline_stall_flush_ctrl.sv - per-stage enable/clear driver for MIPS pipeline registers
module pipeline_stall_flush_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int MEM_WAIT_CYCLES = 2,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      idex_mem_read,
    input  logic [REG_ADDR_WIDTH-1:0] idex_rt,
    input  logic [REG_ADDR_WIDTH-1:0] ifid_rs,
    input  logic [REG_ADDR_WIDTH-1:0] ifid_rt,
    input  logic                      branch_taken,
    input  logic                      exmem_mem_access,
    output logic                      pc_enable,
    output logic                      ifid_enable,
    output logic                      idex_enable,
    output logic                      exmem_enable,
    output logic                      memwb_enable,
    output logic                      ifid_sync_reset,
    output logic                      idex_sync_reset,
    output logic                      exmem_sync_reset,
    output logic                      memwb_sync_reset,
    output logic                      mem_wait_busy,
    output logic [CNT_WIDTH-1:0]      stall_count
);

    localparam int WAIT_W = wait_cnt_width(MEM_WAIT_CYCLES);
    localparam bit WAIT_EN = (MEM_WAIT_CYCLES > 0);
    localparam logic [WAIT_W-1:0] WAIT_LOAD =
        WAIT_EN ? WAIT_W'(MEM_WAIT_CYCLES - 1) : '0;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    ctrl_state_e       state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              load_use;
    logic              start_wait;
    logic              hold_wait;
    logic              in_run;

    hazard_detect_unit #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_hazard (
        .idex_mem_read(idex_mem_read),
        .idex_rt      (idex_rt),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .load_use     (load_use)
    );

    assign in_run     = (state == RUN);
    assign start_wait = WAIT_EN && in_run && exmem_mem_access;
    assign hold_wait  = (state == MEM_WAIT) && (wait_cnt != '0);

    // Zero-latency output mux: commands act on the same edge that sees the inputs.
    always_comb begin
        pc_enable        = 1'b1;
        ifid_enable      = 1'b1;
        idex_enable      = 1'b1;
        exmem_enable     = 1'b1;
        memwb_enable     = 1'b1;
        ifid_sync_reset  = 1'b1;
        idex_sync_reset  = 1'b1;
        exmem_sync_reset = 1'b1;
        memwb_sync_reset = 1'b1;
        mem_wait_busy    = 1'b0;

        if (reset) begin
            pc_enable        = 1'b0;
            ifid_sync_reset  = 1'b0;
            idex_sync_reset  = 1'b0;
            exmem_sync_reset = 1'b0;
            memwb_sync_reset = 1'b0;
        end else begin
            mem_wait_busy = (state == MEM_WAIT);
            if (start_wait || hold_wait) begin
                // Freeze front of pipe; WB gets a bubble so the stalled access is not retired twice.
                pc_enable        = 1'b0;
                ifid_enable      = 1'b0;
                idex_enable      = 1'b0;
                exmem_enable     = 1'b0;
                memwb_sync_reset = 1'b0;
            end else if (in_run && branch_taken) begin
                ifid_sync_reset = 1'b0;
                idex_sync_reset = 1'b0;
            end else if (in_run && load_use) begin
                pc_enable       = 1'b0;
                ifid_enable     = 1'b0;
                idex_sync_reset = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            stall_count <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (start_wait) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_LOAD;
                    end
                end
                MEM_WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else begin
                        state <= RUN;
                    end
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase

            if (!pc_enable && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stall_flush_ctrl.sv
// tb/tb_pipeline_stall_flush_ctrl.sv - self-checking bench for pipeline_stall_flush_ctrl
module tb_pipeline_stall_flush_ctrl;

    localparam int RW  = 5;
    localparam int MWC = 2;
    localparam int CW  = 8;
    localparam int CNT_SAT = (1 << CW) - 1;

    // Output vector order: pc, ifid_en, idex_en, exmem_en, memwb_en, ifid_sr, idex_sr, exmem_sr, memwb_sr, busy
    localparam logic [9:0] O_RST  = 10'b0_1111_0000_0;
    localparam logic [9:0] O_ADV  = 10'b1_1111_1111_0;
    localparam logic [9:0] O_ADVB = 10'b1_1111_1111_1;
    localparam logic [9:0] O_LU   = 10'b0_0111_1011_0;
    localparam logic [9:0] O_BR   = 10'b1_1111_0011_0;
    localparam logic [9:0] O_MW0  = 10'b0_0001_1110_0;
    localparam logic [9:0] O_MW1  = 10'b0_0001_1110_1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          idex_mem_read;
    logic [RW-1:0] idex_rt;
    logic [RW-1:0] ifid_rs;
    logic [RW-1:0] ifid_rt;
    logic          branch_taken;
    logic          exmem_mem_access;
    logic          pc_enable;
    logic          ifid_enable;
    logic          idex_enable;
    logic          exmem_enable;
    logic          memwb_enable;
    logic          ifid_sync_reset;
    logic          idex_sync_reset;
    logic          exmem_sync_reset;
    logic          memwb_sync_reset;
    logic          mem_wait_busy;
    logic [CW-1:0] stall_count;

    pipeline_stall_flush_ctrl #(
        .REG_ADDR_WIDTH (RW),
        .MEM_WAIT_CYCLES(MWC),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .idex_mem_read   (idex_mem_read),
        .idex_rt         (idex_rt),
        .ifid_rs         (ifid_rs),
        .ifid_rt         (ifid_rt),
        .branch_taken    (branch_taken),
        .exmem_mem_access(exmem_mem_access),
        .pc_enable       (pc_enable),
        .ifid_enable     (ifid_enable),
        .idex_enable     (idex_enable),
        .exmem_enable    (exmem_enable),
        .memwb_enable    (memwb_enable),
        .ifid_sync_reset (ifid_sync_reset),
        .idex_sync_reset (idex_sync_reset),
        .exmem_sync_reset(exmem_sync_reset),
        .memwb_sync_reset(memwb_sync_reset),
        .mem_wait_busy   (mem_wait_busy),
        .stall_count     (stall_count)
    );

    typedef struct {
        logic          rst;
        logic          mr;
        logic [RW-1:0] rt;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt2;
        logic          br;
        logic          ma;
        logic [9:0]    exp_out;
        int            exp_cnt;
    } vec_t;

    typedef enum {A_STALL, A_ADV} act_e;

    int   tests = 0;
    int   fails = 0;
    act_e pend[$];
    int   m_cnt = 0;
    vec_t vecs[$];

    function automatic logic [9:0] dut_vec();
        return {pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable,
                ifid_sync_reset, idex_sync_reset, exmem_sync_reset, memwb_sync_reset,
                mem_wait_busy};
    endfunction

    // Reference: a memory access schedules MWC-1 further stall cycles and one forced advance.
    task automatic model_step(output logic [9:0] e, output int c);
        logic lu;
        act_e a;
        c  = m_cnt;
        lu = idex_mem_read && (idex_rt != 0) && ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
        if (reset) begin
            e = O_RST;
            pend.delete();
            m_cnt = 0;
            return;
        end
        if (pend.size() != 0) begin
            a = pend.pop_front();
            e = (a == A_STALL) ? O_MW1 : O_ADVB;
        end else if (exmem_mem_access && MWC > 0) begin
            e = O_MW0;
            for (int i = 0; i < MWC - 1; i++) pend.push_back(A_STALL);
            pend.push_back(A_ADV);
        end else if (branch_taken) begin
            e = O_BR;
        end else if (lu) begin
            e = O_LU;
        end else begin
            e = O_ADV;
        end
        if (!e[9] && m_cnt < CNT_SAT) m_cnt++;
    endtask

    task automatic check_out(input string name, input logic [9:0] got, input logic [9:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s outputs got=%b want=%b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_cnt(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s stall_count got=%0d want=%0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic set_in(input logic rst, input logic mr, input logic [RW-1:0] rt,
                          input logic [RW-1:0] rs, input logic [RW-1:0] rt2,
                          input logic br, input logic ma);
        reset = rst; idex_mem_read = mr; idex_rt = rt; ifid_rs = rs; ifid_rt = rt2;
        branch_taken = br; exmem_mem_access = ma;
    endtask

    // Called just after a falling edge with inputs applied; checks against the model, then moves on.
    task automatic model_cycle(input string name);
        logic [9:0] e;
        int         c;
        #1;
        model_step(e, c);
        check_out(name, dut_vec(), e);
        check_cnt(name, int'(stall_count), c);
        @(negedge clk);
    endtask

    task automatic add(input logic rst, input logic mr, input int rt, input int rs, input int rt2,
                       input logic br, input logic ma, input logic [9:0] eo, input int ec);
        vec_t v;
        v.rst = rst; v.mr = mr; v.rt = RW'(rt); v.rs = RW'(rs); v.rt2 = RW'(rt2);
        v.br = br; v.ma = ma; v.exp_out = eo; v.exp_cnt = ec;
        vecs.push_back(v);
    endtask

    initial begin
        logic [9:0] e_dummy;
        int         c_dummy;

        //    rst mr rt rs rt2 br ma  expected  cnt
        add(1, 0, 0, 0, 0, 0, 0, O_RST,  0);
        add(1, 0, 0, 0, 0, 0, 0, O_RST,  0);
        add(1, 0, 0, 0, 0, 0, 0, O_RST,  0);
        add(0, 0, 0, 0, 0, 0, 0, O_ADV,  0);
        add(0, 1, 8, 8, 1, 0, 0, O_LU,   0);
        add(0, 0, 8, 8, 1, 0, 0, O_ADV,  1);
        add(0, 1, 0, 0, 0, 0, 0, O_ADV,  1);
        add(0, 1, 9, 3, 9, 0, 0, O_LU,   1);
        add(0, 0, 0, 0, 0, 0, 0, O_ADV,  2);
        add(0, 0, 0, 0, 0, 0, 1, O_MW0,  2);
        add(0, 0, 0, 0, 0, 0, 1, O_MW1,  3);
        add(0, 0, 0, 0, 0, 0, 0, O_ADVB, 4);
        add(0, 0, 0, 0, 0, 0, 0, O_ADV,  4);
        add(0, 1, 5, 5, 0, 1, 0, O_BR,   4);
        add(0, 0, 0, 0, 0, 0, 0, O_ADV,  4);
        add(0, 0, 0, 0, 0, 0, 1, O_MW0,  4);
        add(0, 1, 6, 6, 6, 1, 0, O_MW1,  5);
        add(0, 1, 6, 6, 6, 1, 0, O_ADVB, 6);
        add(0, 0, 0, 0, 0, 1, 0, O_BR,   6);
        add(0, 0, 0, 0, 0, 1, 1, O_MW0,  6);
        add(1, 0, 0, 0, 0, 0, 0, O_RST,  7);
        add(0, 0, 0, 0, 0, 0, 0, O_ADV,  0);

        set_in(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        model_step(e_dummy, c_dummy);
        m_cnt = 0;
        pend.delete();

        for (int i = 0; i < vecs.size(); i++) begin
            set_in(vecs[i].rst, vecs[i].mr, vecs[i].rt, vecs[i].rs, vecs[i].rt2, vecs[i].br, vecs[i].ma);
            #1;
            check_out($sformatf("vec%0d", i), dut_vec(), vecs[i].exp_out);
            check_cnt($sformatf("vec%0d", i), int'(stall_count), vecs[i].exp_cnt);
            model_step(e_dummy, c_dummy);
            @(negedge clk);
        end

        // Continuous load-use drives the counter into saturation.
        set_in(0, 1, 7, 7, 2, 0, 0);
        for (int i = 0; i < CNT_SAT + 4; i++) model_cycle("sat_run");
        #1;
        check_cnt("sat_full", int'(stall_count), CNT_SAT);
        set_in(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        model_step(e_dummy, c_dummy);
        #1;
        check_cnt("sat_hold", int'(stall_count), CNT_SAT);
        @(negedge clk);
        model_step(e_dummy, c_dummy);

        set_in(1, 0, 0, 0, 0, 0, 0);
        model_cycle("rand_rst");
        for (int i = 0; i < 1500; i++) begin
            set_in($urandom_range(0, 39) == 0,
                   1'($urandom_range(0, 1)),
                   RW'($urandom_range(0, 3)),
                   RW'($urandom_range(0, 3)),
                   RW'($urandom_range(0, 3)),
                   $urandom_range(0, 4) == 0,
                   $urandom_range(0, 5) == 0);
            model_cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
